// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement a - b, LSB first, with borrow and signed overflow flags
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             over_flow
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, part;
  logic [IW-1:0] idx;
  logic c, nb, s, c_nx, last, accept;
  assign nb     = ~b_sh[0];
  assign s      = a_sh[0] ^ nb ^ c;
  assign c_nx   = (a_sh[0] & nb) | (c & (a_sh[0] ^ nb));
  assign last   = idx == IW'(WIDTH - 1);
  assign accept = state == IDLE && start;
  // state register
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nx;
  // next state and status outputs
  always_comb begin
    state_nx = accept ? RUN : (state == RUN && last) ? FIN : (state == FIN) ? IDLE : state;
    busy     = state == RUN;
    done     = state == FIN;
  end
  // operand shifting, serial full-adder slice and result capture
  always_ff @(posedge clk)
    if (!reset_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      part      <= '0;
      idx       <= '0;
      c         <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      over_flow <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      idx  <= '0;
      c    <= 1'b1;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      part <= {s, part[WIDTH-1:1]};
      c    <= c_nx;
      idx  <= idx + 1'b1;
      if (last) begin
        diff      <= {s, part[WIDTH-1:1]};
        b_out     <= ~c_nx;
        over_flow <= c ^ c_nx;
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic busy, done, b_out, over_flow;
  logic [3:0] diff;
  int n_chk = 0, n_err = 0, cyc = 0;
  logic [3:0] prev_d = '0;
  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out), .over_flow(over_flow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] ed, input logic ebo, input logic eov);
    int busy_n;
    bit got;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = ~av; b = ~bv;
    busy_n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        if (busy) busy_n++;
        check("hold_diff", diff, prev_d);
      end
    end
    check("done_seen", got, 1);
    check("busy_cycles", busy_n, 4);
    check("busy_at_done", busy, 0);
    check("diff", diff, ed);
    check("b_out", b_out, ebo);
    check("over_flow", over_flow, eov);
    @(negedge clk);
    check("done_pulse", done, 0);
    prev_d = ed;
  endtask
  initial begin
    int n_done, t0, t_prev, sa, sb, r;
    bit seen;
    logic [3:0] av, bv;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", b_out, 0);
    check("rst_ovf", over_flow, 0);
    reset_n = 1'b1;
    run_op(4'b0101, 4'b0011, 4'b0010, 0, 0);
    run_op(4'b0011, 4'b0101, 4'b1110, 1, 0);
    run_op(4'b1000, 4'b0001, 4'b0111, 0, 1);
    run_op(4'b0111, 4'b1111, 4'b1000, 1, 1);
    @(negedge clk);
    a = 4'd6; b = 4'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("ign_diff", diff, 4'd4);
        check("ign_bout", b_out, 0);
        check("ign_ovf", over_flow, 0);
      end
      start = (i == 1 || i == 3);
      a = 4'd1; b = 4'd9;
    end
    check("ign_done_count", n_done, 1);
    prev_d = 4'd4;
    @(negedge clk);
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_bout", b_out, 0);
    check("mid_rst_ovf", over_flow, 0);
    reset_n = 1'b1;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_quiet", n_done, 0);
    prev_d = '0;
    run_op(4'b1111, 4'b1111, 4'b0000, 0, 0);
    @(negedge clk);
    a = 4'd0; b = 4'd0; start = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 256; k++) begin
      av = k[7:4]; bv = k[3:0];
      seen = 0;
      for (int j = 0; j < 10 && !seen; j++) begin
        @(negedge clk);
        if (busy) seen = 1;
      end
      check("acc_seen", seen, 1);
      t0 = cyc;
      if (k > 0) check("acc_spacing", t0 - t_prev, 6);
      t_prev = t0;
      a = 4'(av + 4'd1); b = 4'(~bv);
      if (k < 255) begin a = k[3:0] == 4'hf ? 4'(av + 4'd1) : av; b = 4'(bv + 4'd1); end
      seen = 0;
      for (int j = 0; j < 10 && !seen; j++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      check("run_done", seen, 1);
      sa = av >= 8 ? int'(av) - 16 : int'(av);
      sb = bv >= 8 ? int'(bv) - 16 : int'(bv);
      r = sa - sb;
      check("run_diff", diff, 4'(av - bv));
      check("run_bout", b_out, av < bv);
      check("run_ovf", over_flow, (r > 7 || r < -8));
    end
    start = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
